// File: rtl/uram_line_reader.sv
// L2 -> L1 line reader: sequences BEATS URAM reads per accepted line, writes each
// returned beat into L1 and issues an in-order, credit-limited per-stream response.
module uram_line_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int WAYS       = 8,
  parameter int NSTRMS     = 16,
  parameter int NCL        = 128,
  parameter int L1_NCL     = 16,
  parameter int BEATS      = 2,
  parameter int RD_LAT     = 2,
  parameter int RSP_DEPTH  = 4,
  localparam int W  = WAYS * DATA_WIDTH,
  localparam int SW = $clog2(NSTRMS),
  localparam int PW = $clog2(NCL),
  localparam int LW = $clog2(L1_NCL),
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk2x,
  input  logic                 reset,
  input  logic                 i_req_v,
  output logic                 i_req_r,
  input  logic [SW-1:0]        i_req_sid,
  input  logic [PW-1:0]        i_req_ptr,
  output logic                 o_ram_re,
  output logic [SW+PW+BW-1:0]  o_ram_ra,
  input  logic [W-1:0]         i_ram_rd,
  output logic                 o_we,
  output logic [SW+LW+BW-1:0]  o_wa,
  output logic [W-1:0]         o_wd,
  output logic [NSTRMS-1:0]    o_rsp_v,
  input  logic [NSTRMS-1:0]    i_rsp_r
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int FW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  typedef struct packed {
    logic [SW-1:0] sid;
    logic [LW-1:0] lptr;
    logic [BW-1:0] b;
    logic          last;
  } beat_t;

  logic [0:0]    state_q;
  logic [BW-1:0] b_q;
  logic [SW-1:0] sid_q;
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] credit_q;
  logic          accept;
  logic          last_beat;
  logic          issue;
  logic          pop;

  assign last_beat = (b_q == BW'(BEATS - 1));
  assign issue     = (state_q == ISSUE) && !reset;
  assign i_req_r   = !reset && ((state_q == IDLE) || ((state_q == ISSUE) && last_beat))
                     && (credit_q < CW'(RSP_DEPTH));
  assign accept    = i_req_v && i_req_r;
  assign o_ram_re  = issue;
  assign o_ram_ra  = issue ? {sid_q, ptr_q, b_q} : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk2x) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      sid_q   <= '0;
      ptr_q   <= '0;
    end else if (accept) begin
      state_q <= ISSUE;
      b_q     <= '0;
      sid_q   <= i_req_sid;
      ptr_q   <= i_req_ptr;
    end else if (state_q == ISSUE) begin
      if (last_beat) begin
        state_q <= IDLE;
        b_q     <= '0;
      end else begin
        b_q <= b_q + BW'(1);
      end
    end
  end

  // Read-latency pipe: valid bits are reset, the payload only travels with them.
  logic [RD_LAT-1:0] pv_q;
  beat_t             pd_q [RD_LAT];
  beat_t             pipe_in;
  beat_t             wr;

  assign pipe_in = '{sid: sid_q, lptr: ptr_q[LW-1:0], b: b_q, last: last_beat};

  always_ff @(posedge clk2x) begin
    if (reset) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= issue;
      for (int k = 1; k < RD_LAT; k++) pv_q[k] <= pv_q[k-1];
    end
  end

  always_ff @(posedge clk2x) begin
    pd_q[0] <= pipe_in;
    for (int k = 1; k < RD_LAT; k++) pd_q[k] <= pd_q[k-1];
  end

  assign wr   = pd_q[RD_LAT-1];
  assign o_we = pv_q[RD_LAT-1] && !reset;
  assign o_wa = o_we ? {wr.sid, wr.lptr, wr.b} : '0;
  assign o_wd = i_ram_rd;

  // Response FIFO; o_rsp_v is registered from the post-update head.
  logic [SW-1:0]     fifo_mem [RSP_DEPTH];
  logic [FW-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
  logic [CW-1:0]     count_q, count_d, remaining;
  logic [SW-1:0]     head_d;
  logic [NSTRMS-1:0] rsp_v_q, rsp_v_d;
  logic              push;

  function automatic logic [FW-1:0] wrap_inc(input logic [FW-1:0] p);
    return (p == FW'(RSP_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  assign push    = o_we && wr.last;
  assign o_rsp_v = reset ? '0 : rsp_v_q;
  assign pop     = |(o_rsp_v & i_rsp_r);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d   = count_q;
    rd_next   = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    remaining = count_q - CW'(pop);
    head_d    = wr.sid;
    rsp_v_d   = '0;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (remaining != '0) head_d = fifo_mem[rd_next];
    if (count_d != '0)   rsp_v_d = NSTRMS'(1) << head_d;
  end

  always_ff @(posedge clk2x) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rsp_v_q  <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_next;
      rsp_v_q  <= rsp_v_d;
      if (push) wr_ptr_q <= wrap_inc(wr_ptr_q);
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers alone decide which entries are live.
  always_ff @(posedge clk2x) begin
    if (push) fifo_mem[wr_ptr_q] <= wr.sid;
  end

  // A pop frees its credit for the following cycle, since i_req_r reads credit_q.
  always_ff @(posedge clk2x) begin
    if (reset)               credit_q <= '0;
    else if (accept && !pop) credit_q <= credit_q + CW'(1);
    else if (pop && !accept) credit_q <= credit_q - CW'(1);
  end

endmodule

// File: tb/tb_uram_line_reader.sv
// Directed bench for uram_line_reader: defaults instance plus two parameter-sweep
// instances (BEATS=1/RD_LAT=1 and BEATS=4/RD_LAT=3), each with a URAM latency model.
module tb_uram_line_reader;
  localparam int W = 512;

  logic clk2x = 1'b0;
  always #5 clk2x = ~clk2x;

  logic        reset;
  logic [3:0]  req_sid;
  logic [6:0]  req_ptr;
  logic [15:0] all_ready = '1;

  // default instance
  logic req_v, req_r, ram_re, we;
  logic [11:0] ram_ra;
  logic [8:0]  wa;
  logic [W-1:0] ram_rd, wd;
  logic [15:0] rsp_v, rsp_r;

  // BEATS=1, RD_LAT=1
  logic a_req_v, a_req_r, a_ram_re, a_we;
  logic [11:0] a_ram_ra;
  logic [8:0]  a_wa;
  logic [W-1:0] a_ram_rd, a_wd;
  logic [15:0] a_rsp_v;

  // BEATS=4, RD_LAT=3
  logic b_req_v, b_req_r, b_ram_re, b_we;
  logic [12:0] b_ram_ra;
  logic [9:0]  b_wa;
  logic [W-1:0] b_ram_rd, b_wd;
  logic [15:0] b_rsp_v;

  uram_line_reader dut (
    .clk2x(clk2x), .reset(reset), .i_req_v(req_v), .i_req_r(req_r),
    .i_req_sid(req_sid), .i_req_ptr(req_ptr), .o_ram_re(ram_re), .o_ram_ra(ram_ra),
    .i_ram_rd(ram_rd), .o_we(we), .o_wa(wa), .o_wd(wd), .o_rsp_v(rsp_v), .i_rsp_r(rsp_r));

  uram_line_reader #(.BEATS(1), .RD_LAT(1)) dut_a (
    .clk2x(clk2x), .reset(reset), .i_req_v(a_req_v), .i_req_r(a_req_r),
    .i_req_sid(req_sid), .i_req_ptr(req_ptr), .o_ram_re(a_ram_re), .o_ram_ra(a_ram_ra),
    .i_ram_rd(a_ram_rd), .o_we(a_we), .o_wa(a_wa), .o_wd(a_wd), .o_rsp_v(a_rsp_v),
    .i_rsp_r(all_ready));

  uram_line_reader #(.BEATS(4), .RD_LAT(3)) dut_b (
    .clk2x(clk2x), .reset(reset), .i_req_v(b_req_v), .i_req_r(b_req_r),
    .i_req_sid(req_sid), .i_req_ptr(req_ptr), .o_ram_re(b_ram_re), .o_ram_ra(b_ram_ra),
    .i_ram_rd(b_ram_rd), .o_we(b_we), .o_wa(b_wa), .o_wd(b_wd), .o_rsp_v(b_rsp_v),
    .i_rsp_r(all_ready));

  // URAM contents are a fixed function of the address.
  function automatic logic [W-1:0] data_of(input logic [15:0] addr);
    logic [W-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = ({16'h0, addr} * 32'h9E37_79B1) + 32'(i);
    return d;
  endfunction

  logic [11:0] m_hist [2];
  logic [11:0] a_hist;
  logic [12:0] b_hist [3];
  always @(posedge clk2x) begin
    m_hist[0] <= ram_ra;   m_hist[1] <= m_hist[0];
    a_hist    <= a_ram_ra;
    b_hist[0] <= b_ram_ra; b_hist[1] <= b_hist[0]; b_hist[2] <= b_hist[1];
  end
  assign ram_rd   = data_of(16'(m_hist[1]));
  assign a_ram_rd = data_of(16'(a_hist));
  assign b_ram_rd = data_of(16'(b_hist[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  bp_sid [6];
  logic        exp_re, exp_we, acc_prev;
  logic [15:0] exp_rsp;
  int          k, bt, idx, n_acc, a_cnt, b_cnt, a_lat, b_lat, n_we, lat;

  initial begin
    bp_sid = '{4'd2, 4'd7, 4'd9, 4'd4, 4'd11, 4'd13};
    reset = 1'b1; req_v = 1'b0; a_req_v = 1'b0; b_req_v = 1'b0;
    req_sid = '0; req_ptr = '0; rsp_r = '1;

    repeat (2) @(negedge clk2x);
    check("rst_req_r", req_r, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_we", we, 0);
    check("rst_rsp_v", rsp_v, 0);
    check("rst_ram_ra", ram_ra, 0);
    check("rst_wa", wa, 0);
    reset = 1'b0;
    @(negedge clk2x);
    check("idle_req_r", req_r, 1);

    // single line: sid 3, ptr 0x25 accepted at T
    req_v = 1'b1; req_sid = 4'd3; req_ptr = 7'h25;
    @(negedge clk2x);  // T+1
    req_v = 1'b0;
    check("t1_re0", ram_re, 1);
    check("t1_ra0", ram_ra, {4'd3, 7'h25, 1'b0});
    @(negedge clk2x);  // T+2
    check("t1_re1", ram_re, 1);
    check("t1_ra1", ram_ra, {4'd3, 7'h25, 1'b1});
    check("t1_req_r_last", req_r, 1);
    @(negedge clk2x);  // T+3
    check("t1_re_off", ram_re, 0);
    check("t1_we0", we, 1);
    check("t1_wa0", wa, {4'd3, 4'd5, 1'b0});
    check("t1_wd0", wd, data_of(16'({4'd3, 7'h25, 1'b0})));
    @(negedge clk2x);  // T+4
    check("t1_we1", we, 1);
    check("t1_wa1", wa, {4'd3, 4'd5, 1'b1});
    check("t1_wd1", wd, data_of(16'({4'd3, 7'h25, 1'b1})));
    check("t1_rsp_early", rsp_v, 0);
    @(negedge clk2x);  // T+5
    check("t1_we_off", we, 0);
    check("t1_rsp", rsp_v, 16'h0008);
    @(negedge clk2x);  // T+6
    check("t1_rsp_pop", rsp_v, 0);

    // back-to-back: 8 lines, line k = sid k, ptr 0x10+k, offered at cycle 2k
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk2x);
      exp_re = (c >= 1 && c <= 16);
      check("s_re", ram_re, exp_re);
      if (exp_re) begin
        k = (c - 1) / 2; bt = (c - 1) % 2;
        check("s_ra", ram_ra, {4'(k), 7'(16 + k), 1'(bt)});
      end
      exp_we = (c >= 3 && c <= 18);
      check("s_we", we, exp_we);
      if (exp_we) begin
        k = (c - 3) / 2; bt = (c - 3) % 2;
        check("s_wa", wa, {4'(k), 4'(k), 1'(bt)});
        check("s_wd", wd, data_of(16'({4'(k), 7'(16 + k), 1'(bt)})));
      end
      exp_rsp = '0;
      if (c >= 5 && (c - 5) % 2 == 0 && (c - 5) / 2 < 8) exp_rsp = 16'(1) << ((c - 5) / 2);
      check("s_rsp", rsp_v, exp_rsp);
      if (c < 16 && c % 2 == 0) begin
        check("s_req_r", req_r, 1);
        req_v = 1'b1; req_sid = 4'(c / 2); req_ptr = 7'(16 + c / 2);
      end else if (c == 16) begin
        req_v = 1'b0;
      end
    end

    // backpressure: no ready, 6 offered, 4 accepted
    rsp_r = '0;
    idx = 0; n_acc = 0; acc_prev = 1'b0;
    req_v = 1'b1; req_sid = bp_sid[0]; req_ptr = 7'h40;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk2x);
      if (acc_prev) begin
        idx++;
        if (idx < 6) begin req_sid = bp_sid[idx]; req_ptr = 7'(64 + idx); end
        else req_v = 1'b0;
      end
      acc_prev = req_v && req_r;
      if (acc_prev) n_acc++;
    end
    check("bp_accepts", n_acc, 4);
    check("bp_req_r", req_r, 0);
    check("bp_head", rsp_v, 16'h0004);

    // per-stream blocking: ready on sid 5 must not pop head sid 2
    rsp_r = 16'h0020;
    repeat (3) begin
      @(negedge clk2x);
      check("blk_head", rsp_v, 16'h0004);
      check("blk_req_r", req_r, 0);
    end
    rsp_r = 16'h0004;
    @(negedge clk2x);
    check("pop_next_head", rsp_v, 16'h0080);
    check("pop_req_r", req_r, 1);
    rsp_r = '0;  // sid 11 line is accepted at this edge
    @(negedge clk2x);
    req_v = 1'b0; rsp_r = '1;
    check("drain_7", rsp_v, 16'h0080);
    @(negedge clk2x); check("drain_9", rsp_v, 16'h0200);
    @(negedge clk2x); check("drain_4", rsp_v, 16'h0010);
    @(negedge clk2x); check("drain_gap", rsp_v, 16'h0000);
    @(negedge clk2x); check("drain_11", rsp_v, 16'h0800);
    @(negedge clk2x); check("drain_empty", rsp_v, 16'h0000);
    check("drain_req_r", req_r, 1);

    // parameter sweep: sid 6, ptr 0x41 into both sweep instances at T
    a_req_v = 1'b1; b_req_v = 1'b1; req_sid = 4'd6; req_ptr = 7'h41;
    a_cnt = 0; b_cnt = 0; a_lat = -1; b_lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk2x);
      if (c == 1) begin a_req_v = 1'b0; b_req_v = 1'b0; end
      if (a_we) begin
        check("a_wa", a_wa, {4'd6, 4'd1, 1'b0});
        check("a_wd", a_wd, data_of(16'({4'd6, 7'h41, 1'b0})));
        a_cnt++;
      end
      if (b_we) begin
        check("b_wa", b_wa, {4'd6, 4'd1, 2'(b_cnt)});
        check("b_wd", b_wd, data_of(16'({4'd6, 7'h41, 2'(b_cnt)})));
        b_cnt++;
      end
      if (a_rsp_v != 0 && a_lat < 0) begin a_lat = c; check("a_rsp", a_rsp_v, 16'h0040); end
      if (b_rsp_v != 0 && b_lat < 0) begin b_lat = c; check("b_rsp", b_rsp_v, 16'h0040); end
    end
    check("a_we_count", a_cnt, 1);
    check("b_we_count", b_cnt, 4);
    check("a_rsp_latency", a_lat, 3);
    check("b_rsp_latency", b_lat, 8);

    // reset mid-line: accept at T, reset during T+2
    req_v = 1'b1; req_sid = 4'd1; req_ptr = 7'h33;
    @(negedge clk2x);
    req_v = 1'b0;
    check("mid_re", ram_re, 1);
    @(negedge clk2x);
    reset = 1'b1;
    #1;
    check("mid_rst_re", ram_re, 0);
    check("mid_rst_req_r", req_r, 0);
    @(negedge clk2x);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk2x);
      check("mid_no_we", we, 0);
      check("mid_no_rsp", rsp_v, 0);
      check("mid_no_re", ram_re, 0);
    end
    check("mid_req_r", req_r, 1);

    // next request serviced normally: sid 4, ptr 0x12
    req_v = 1'b1; req_sid = 4'd4; req_ptr = 7'h12;
    n_we = 0; lat = -1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk2x);
      if (c == 1) req_v = 1'b0;
      if (we) begin
        check("rec_wa", wa, {4'd4, 4'd2, 1'(n_we)});
        n_we++;
      end
      check("rec_rsp", rsp_v, (c == 5) ? 16'h0010 : 16'h0000);
    end
    check("rec_we_count", n_we, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
